// File: rtl/led_frame_ctrl_pkg.sv
// led_ctrl_pkg: shared constants, instruction codes and FSM encoding for the LED frame controller
package led_ctrl_pkg;
    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 2;
    localparam int FRAME_W = ADDR_W + INSTR_W;
    localparam logic [INSTR_W-1:0] INSTR_OFF     = 2'b00;
    localparam logic [INSTR_W-1:0] INSTR_ON      = 2'b01;
    localparam logic [INSTR_W-1:0] INSTR_BLINK   = 2'b10;
    localparam logic [INSTR_W-1:0] INSTR_BLINK_N = 2'b11;
    localparam logic [ADDR_W-1:0]  BROADCAST_ADDR = 6'd63;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/led_frame_ctrl_if.sv
// led_frame_ctrl_if: serial frame inputs and LED state outputs of the frame controller
interface led_frame_ctrl_if
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 20
);
    logic                        SCLK;
    logic                        DATA;
    logic                        LATCH;
    logic [NUM_LEDS*INSTR_W-1:0] LED_STATE;
    logic                        PATTERN;
    logic                        FRAME_OK;
    logic                        FRAME_ERR;
    modport master (output SCLK, DATA, LATCH, input LED_STATE, PATTERN, FRAME_OK, FRAME_ERR);
    modport slave  (input SCLK, DATA, LATCH, output LED_STATE, PATTERN, FRAME_OK, FRAME_ERR);
endinterface

// File: rtl/led_frame_ctrl_sync_edge.sv
// sync_edge: multi-flop synchronizer with a delayed copy for rise/fall detection
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    // shift the raw input through the chain; the delayed copy trails the last stage by one cycle
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        dly_d  = sync_q[SYNC_STAGES-1];
    end
    // synchronizer and delay flops
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end
    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;
endmodule

// File: rtl/led_frame_ctrl.sv
// led_frame_ctrl: receives serial LED frames, validates them and commits per-LED states plus blink pattern
module led_frame_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS    = 20,
    parameter int SYNC_STAGES = 2,
    parameter int BLINK_W     = 22
) (
    input logic CLK,
    input logic RESET,
    led_frame_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_W + 2);
    logic sclk_rise, latch_rise, latch_fall, data_lvl;
    logic sclk_lvl_unused, sclk_fall_unused, latch_lvl_unused, data_rise_unused, data_fall_unused;
    state_t                      state_q, state_d;
    logic [FRAME_W-1:0]          shift_q, shift_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_LEDS*INSTR_W-1:0] led_state_q, led_state_d;
    logic                        frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic [BLINK_W-1:0]          blink_q, blink_d;
    logic                        pattern_q, pattern_d;
    logic [ADDR_W-1:0]           addr;
    logic [INSTR_W-1:0]          instr;
    logic                        frame_bad;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .CLK(CLK), .RESET(RESET), .d(bus.SCLK),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data (
        .CLK(CLK), .RESET(RESET), .d(bus.DATA),
        .level(data_lvl), .rise(data_rise_unused), .fall(data_fall_unused)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch (
        .CLK(CLK), .RESET(RESET), .d(bus.LATCH),
        .level(latch_lvl_unused), .rise(latch_rise), .fall(latch_fall)
    );

    assign addr      = shift_q[ADDR_W-1:0];
    assign instr     = shift_q[FRAME_W-1 -: INSTR_W];
    assign frame_bad = (cnt_q != CNT_W'(FRAME_W)) ||
                       (addr >= ADDR_W'(NUM_LEDS) && addr != BROADCAST_ADDR);

    // frame FSM: shift bits while LATCH is high, validate and write the register file in COMMIT
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        led_state_d = led_state_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: if (latch_rise) begin
                state_d = SHIFT;
                shift_d = '0;
                cnt_d   = '0;
            end
            SHIFT: if (latch_fall) begin
                state_d = COMMIT;
            end else if (sclk_rise) begin
                shift_d = {shift_q[FRAME_W-2:0], data_lvl};
                cnt_d   = (cnt_q == CNT_W'(FRAME_W + 1)) ? cnt_q : cnt_q + 1'b1;
            end
            COMMIT: begin
                state_d = latch_rise ? SHIFT : IDLE;
                if (latch_rise) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end
                frame_err_d = frame_bad;
                frame_ok_d  = ~frame_bad;
                if (!frame_bad)
                    for (int i = 0; i < NUM_LEDS; i++)
                        if (addr == BROADCAST_ADDR || addr == ADDR_W'(i))
                            led_state_d[i*INSTR_W +: INSTR_W] = instr;
            end
            default: state_d = IDLE;
        endcase
    end

    // free-running blink counter; PATTERN loads the counter's next MSB so it stays in phase with it
    always_comb begin
        blink_d   = blink_q + 1'b1;
        pattern_d = blink_d[BLINK_W-1];
    end

    // state registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            led_state_q <= {NUM_LEDS{INSTR_OFF}};
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            blink_q     <= '0;
            pattern_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            led_state_q <= led_state_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            blink_q     <= blink_d;
            pattern_q   <= pattern_d;
        end
    end

    assign bus.LED_STATE = led_state_q;
    assign bus.PATTERN   = pattern_q;
    assign bus.FRAME_OK  = frame_ok_q;
    assign bus.FRAME_ERR = frame_err_q;
endmodule

// File: tb/tb_led_frame_ctrl.sv
// tb_led_frame_ctrl: directed table, reset corner case and randomized frames against a behavioural model
module tb_led_frame_ctrl;
    localparam int NL = 20;

    typedef struct {
        logic [8:0]  bits;
        int          n;
        bit          coinc;
        bit          ok;
        bit          err;
        logic [39:0] st;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET;
    int   tests = 0;
    int   fails = 0;
    int   since_rel;
    bit   chk_pat = 1'b0;
    logic [1:0]  model_led [NL];
    logic [39:0] cur_exp;
    vec_t tbl [10];

    led_frame_ctrl_if #(.NUM_LEDS(NL)) bus ();

    led_frame_ctrl #(.NUM_LEDS(NL), .SYNC_STAGES(2), .BLINK_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESET)
        if (!RESET) since_rel <= 0;
        else        since_rel <= since_rel + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK)
        if (chk_pat && RESET === 1'b1)
            chk("pattern", {63'd0, bus.PATTERN}, {63'd0, ((since_rel % 16) >= 8)});

    task automatic wait_n(input int k);
        repeat (k) @(negedge CLK);
    endtask

    function automatic logic [39:0] model_pack();
        logic [39:0] p;
        for (int i = 0; i < NL; i++) p[2*i +: 2] = model_led[i];
        return p;
    endfunction

    task automatic model_apply(input logic [8:0] bits, input int n, input bit coinc,
                               output bit ok, output bit err);
        int          en;
        logic [8:0]  v;
        int          a;
        en  = coinc ? n - 1 : n;
        v   = coinc ? bits >> 1 : bits;
        a   = int'(v[5:0]);
        ok  = 1'b0;
        err = 1'b1;
        if (en == 8 && (a < NL || a == 63)) begin
            ok  = 1'b1;
            err = 1'b0;
            for (int i = 0; i < NL; i++)
                if (a == 63 || a == i) model_led[i] = v[7:6];
        end
    endtask

    task automatic run_frame(input string nm, input logic [8:0] bits, input int n, input bit coinc,
                             input bit eok, input bit eerr, input logic [39:0] est);
        bit          early_ok = 1'b1;
        bit          late_ok  = 1'b1;
        logic [39:0] st4 = '0;
        logic [1:0]  p4 = '0;
        bus.LATCH = 1'b1;
        wait_n(2);
        for (int i = 0; i < n; i++) begin
            bus.DATA = bits[n-1-i];
            wait_n(2);
            bus.SCLK = 1'b1;
            if (coinc && i == n - 1) begin
                bus.LATCH = 1'b0;
            end else begin
                wait_n(2);
                bus.SCLK = 1'b0;
            end
        end
        if (!(coinc && n > 0)) begin
            wait_n(2);
            bus.LATCH = 1'b0;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k < 4) begin
                if (bus.LED_STATE !== cur_exp || bus.FRAME_OK !== 1'b0 || bus.FRAME_ERR !== 1'b0) early_ok = 1'b0;
            end else if (k == 4) begin
                st4 = bus.LED_STATE;
                p4  = {bus.FRAME_OK, bus.FRAME_ERR};
            end else begin
                if (bus.LED_STATE !== est || bus.FRAME_OK !== 1'b0 || bus.FRAME_ERR !== 1'b0) late_ok = 1'b0;
            end
        end
        bus.SCLK = 1'b0;
        chk({nm, ".before_latency"}, {63'd0, early_ok}, 64'd1);
        chk({nm, ".state"}, {24'd0, st4}, {24'd0, est});
        chk({nm, ".ok_err"}, {62'd0, p4}, {62'd0, eok, eerr});
        chk({nm, ".after"}, {63'd0, late_ok}, 64'd1);
        cur_exp = est;
    endtask

    initial begin
        int          cnt;
        bit          ok, err, quiet;
        logic [8:0]  bits;
        int          n;
        bit          coinc;

        tbl[0] = '{9'b0_01_000011, 8, 1'b0, 1'b1, 1'b0, 40'h00_0000_0040};
        tbl[1] = '{9'b0_10_111111, 8, 1'b0, 1'b1, 1'b0, 40'hAA_AAAA_AAAA};
        tbl[2] = '{9'b0_00_000000, 8, 1'b0, 1'b1, 1'b0, 40'hAA_AAAA_AAA8};
        tbl[3] = '{9'b0_11_010100, 8, 1'b0, 1'b0, 1'b1, 40'hAA_AAAA_AAA8};
        tbl[4] = '{9'b00_0110001,  7, 1'b0, 1'b0, 1'b1, 40'hAA_AAAA_AAA8};
        tbl[5] = '{9'b1_01_000010, 9, 1'b0, 1'b0, 1'b1, 40'hAA_AAAA_AAA8};
        tbl[6] = '{9'b0_01_000101, 8, 1'b1, 1'b0, 1'b1, 40'hAA_AAAA_AAA8};
        tbl[7] = '{9'b0,           0, 1'b0, 1'b0, 1'b1, 40'hAA_AAAA_AAA8};
        tbl[8] = '{9'b0_11_010011, 8, 1'b0, 1'b1, 1'b0, 40'hEA_AAAA_AAA8};
        tbl[9] = '{9'b0_01_111110, 8, 1'b0, 1'b0, 1'b1, 40'hEA_AAAA_AAA8};
        for (int i = 0; i < NL; i++) model_led[i] = 2'b00;
        cur_exp   = '0;
        RESET     = 1'b0;
        bus.SCLK  = 1'b0;
        bus.DATA  = 1'b0;
        bus.LATCH = 1'b0;
        wait_n(3);
        #1;
        chk("reset.led_state", {24'd0, bus.LED_STATE}, 64'd0);
        chk("reset.flags", {61'd0, bus.PATTERN, bus.FRAME_OK, bus.FRAME_ERR}, 64'd0);
        wait_n(1);
        RESET = 1'b1;
        cnt = 0;
        while (bus.PATTERN !== 1'b1 && cnt < 40) begin
            @(negedge CLK);
            cnt++;
        end
        chk("pattern.first_rise", cnt, 8);
        cnt = 0;
        while (bus.PATTERN !== 1'b0 && cnt < 40) begin
            @(negedge CLK);
            cnt++;
        end
        chk("pattern.high_time", cnt, 8);
        chk_pat = 1'b1;

        for (int i = 0; i < 10; i++) begin
            model_apply(tbl[i].bits, tbl[i].n, tbl[i].coinc, ok, err);
            run_frame($sformatf("tbl%0d", i), tbl[i].bits, tbl[i].n, tbl[i].coinc,
                      tbl[i].ok, tbl[i].err, tbl[i].st);
        end

        bus.LATCH = 1'b1;
        wait_n(2);
        for (int i = 0; i < 4; i++) begin
            bus.DATA = i[0];
            wait_n(2);
            bus.SCLK = 1'b1;
            wait_n(2);
            bus.SCLK = 1'b0;
        end
        RESET = 1'b0;
        #1;
        chk("midreset.led_state", {24'd0, bus.LED_STATE}, 64'd0);
        chk("midreset.flags", {62'd0, bus.FRAME_OK, bus.FRAME_ERR}, 64'd0);
        wait_n(3);
        bus.LATCH = 1'b0;
        bus.DATA  = 1'b0;
        wait_n(3);
        RESET = 1'b1;
        for (int i = 0; i < NL; i++) model_led[i] = 2'b00;
        cur_exp = '0;
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus.LED_STATE !== 40'd0 || bus.FRAME_OK !== 1'b0 || bus.FRAME_ERR !== 1'b0) quiet = 1'b0;
        end
        chk("midreset.quiet_after_release", {63'd0, quiet}, 64'd1);
        model_apply(9'b0_01_000001, 8, 1'b0, ok, err);
        run_frame("post_reset", 9'b0_01_000001, 8, 1'b0, 1'b1, 1'b0, 40'h00_0000_0004);

        for (int t = 0; t < 40; t++) begin
            cnt = int'($urandom_range(0, 9));
            n = (cnt < 6) ? 8 : (cnt == 6) ? 7 : (cnt == 7) ? 9 : (cnt == 8) ? 0 : 8;
            bits = 9'($urandom);
            if (n == 8) begin
                bits[8] = 1'b0;
                if ($urandom_range(0, 4) == 0) bits[5:0] = 6'd63;
                else if ($urandom_range(0, 1) == 0) bits[5:0] = 6'($urandom_range(0, NL - 1));
            end
            coinc = (n > 0) && ($urandom_range(0, 7) == 0);
            model_apply(bits, n, coinc, ok, err);
            run_frame($sformatf("rnd%0d", t), bits, n, coinc, ok, err, model_pack());
        end

        chk_pat = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
